ram_vector_streamer: RTL and testbench
======================================

# ram_vector_streamer

Parametrised RAM-to-array streamer for the brightness systolic path. On `start` it reads a programmable span of pixels from a synchronous single-port RAM and packs them into `LANES`-wide vectors, widening each pixel to the PE data width. It presents the vectors to the systolic array front-end over a valid/ready handshake with backpressure. The last vector is zero-padded when the span is not a multiple of `LANES`, and the block signals completion with a `last` flag and a `done` pulse.

## Interface
- `RAM_ADDR_WIDTH`, 6: RAM address bits; the span wraps modulo 2^RAM_ADDR_WIDTH.
- `RAM_DATA_WIDTH`, 8: pixel width.
- `PE_DATA_WIDTH`, 16: lane width; must be ≥ RAM_DATA_WIDTH.
- `LANES`, 4: words per output vector; must be ≥ 2.
- `SIGN_EXTEND`, 0: 0 zero-extends pixels to PE_DATA_WIDTH; 1 replicates the pixel MSB.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a transfer; sampled only in IDLE.
- `start_addr`  in  RAM_ADDR_WIDTH  first RAM address; captured with `start`.
- `num_words`  in  RAM_ADDR_WIDTH+1  span length in pixels (0..2^RAM_ADDR_WIDTH); captured with `start`.
- `ram_address`  out  RAM_ADDR_WIDTH  read address; 0 when `ram_rd_en`=0.
- `ram_rd_en`  out  1  read strobe; `ram_data` is valid exactly one cycle later.
- `ram_data`  in  RAM_DATA_WIDTH  RAM read data.
- `data_out`  out  PE_DATA_WIDTH*LANES  vector; lane 0 (first pixel) occupies the LSBs.
- `data_valid`  out  1  `data_out` holds a vector.
- `data_ready`  in  1  consumer accepts the vector.
- `data_last`  out  1  qualifies the final vector of the span.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: `start`=1 captures `start_addr` and `num_words`. Goes to FETCH, or to DONE_ST if `num_words`=0.
  - FETCH: issues reads and fills vectors. After the final read has been issued, goes to DRAIN.
  - DRAIN: waits until the last vector is accepted, then goes to DONE_ST.
  - DONE_ST: asserts `done` for one cycle, then returns to IDLE.
- Addressing: the i-th read uses address (start_addr + i) mod 2^RAM_ADDR_WIDTH, with i = 0..num_words-1. One read per cycle unless stalled.
- Fill buffer: holds LANES-1 words.
  - Non-final words of a vector are captured into the buffer lane indexed by the lane counter.
  - The final word of a vector (lane LANES-1, or the last word of the span) is written straight into the output register together with the buffer contents. Unfilled lanes are set to 0.
- Widening: each pixel is zero- or sign-extended per SIGN_EXTEND. Pad lanes are always 0.
- Handshake: a vector transfers on a cycle with `data_valid`=1 and `data_ready`=1. While `data_ready`=0, `data_out`, `data_valid` and `data_last` hold stable.
- Stall rule: the read for a vector's final word is issued only in a cycle where `data_valid`=0 or `data_ready`=1. Otherwise `ram_rd_en` stays 0 and the address is held. This guarantees the output register is free when that word arrives. No data is lost or duplicated.
- Vector count: ceil(num_words/LANES). `data_last`=1 only with the last vector.
- `start` is ignored outside IDLE. A new `start` is accepted in the cycle after `done`.

## Timing
- Reset values: all outputs 0, state IDLE, fill buffer and output register 0.
- Reset mid-operation: asserting `reset_n`=0 clears everything immediately (asynchronous). Any partial vector is discarded.
- With `start` sampled at edge T and `data_ready`=1:
  - reads are issued in cycles T+1..T+LANES;
  - `data_valid` rises after edge T+LANES+1 (latency LANES+1 cycles);
  - sustained throughput is one vector per LANES cycles.
- `done` asserts in the cycle after the edge at which the last vector is accepted. `busy` falls with `done`.
- `num_words`=0: `done` pulses in cycle T+1 and `data_valid` never rises.
- A full span of 2^RAM_ADDR_WIDTH words reads every address exactly once. A span crossing the top address wraps to 0.

## Test plan
All scenarios use RAM_ADDR_WIDTH=6, LANES=4, RAM contents mem[i]=i unless stated.
- Full span, ready held high: start_addr=0, num_words=64.
  - Required: 16 vectors; first `data_out`=0x0003_0002_0001_0000 with `data_valid` rising after T+5.
  - Last vector 0x003F_003E_003D_003C with `data_last`=1, then a single `done` pulse.
- Partial span: start_addr=10, num_words=6.
  - Required: 0x000D_000C_000B_000A, then 0x0000_0000_000F_000E with `data_last`=1.
- Wrap-around: start_addr=62, num_words=4.
  - Required: reads at addresses 62, 63, 0, 1; single vector 0x0001_0000_003F_003E with `data_last`=1.
- Backpressure: num_words=16; hold `data_ready`=0 for 10 cycles once the first vector is valid.
  - Required: `data_out` stays stable; exactly 3 further reads are issued, then `ram_rd_en` stays 0.
  - After release: all 4 vectors arrive in order, with none dropped or duplicated.
- Modes:
  - SIGN_EXTEND=1, mem[0]=0x80, num_words=1 → 0x0000_0000_0000_FF80.
  - num_words=0 → `done` pulse at T+1 with no `data_valid`.
  - `start` pulsed while `busy`=1 → ignored.
- Reset: drive `reset_n` low mid-stream → all outputs 0 within the same cycle. A subsequent `start` streams correctly from a clean state.

Source files
------------

// File: rtl/ram_vector_streamer.sv
// Streams a span of RAM pixels into LANES-wide, widened vectors with valid/ready backpressure.
// The last vector of a span is zero-padded and flagged with data_last; done pulses at completion.
module ram_vector_streamer #(
  parameter int RAM_ADDR_WIDTH = 6,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int PE_DATA_WIDTH  = 16,
  parameter int LANES          = 4,
  parameter int SIGN_EXTEND    = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [RAM_ADDR_WIDTH-1:0]         start_addr,
  input  logic [RAM_ADDR_WIDTH:0]           num_words,
  output logic [RAM_ADDR_WIDTH-1:0]         ram_address,
  output logic                              ram_rd_en,
  input  logic [RAM_DATA_WIDTH-1:0]         ram_data,
  output logic [PE_DATA_WIDTH*LANES-1:0]    data_out,
  output logic                              data_valid,
  input  logic                              data_ready,
  output logic                              data_last,
  output logic                              busy,
  output logic                              done
);

  localparam int AW = RAM_ADDR_WIDTH;
  localparam int DW = RAM_DATA_WIDTH;
  localparam int PW = PE_DATA_WIDTH;
  localparam int LW = (LANES > 2) ? $clog2(LANES) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] DONE_ST = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [AW:0]         remain_q, remain_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic                pend_q, pend_d;
  logic [LW-1:0]       pend_lane_q, pend_lane_d;
  logic                pend_final_q, pend_final_d;
  logic                pend_last_q, pend_last_d;
  logic [PW-1:0]       buf_q [LANES-1];
  logic [PW-1:0]       buf_d [LANES-1];
  logic [PW*LANES-1:0] out_q, out_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;

  logic                is_final;
  logic                out_free;
  logic                issue;
  logic [PW-1:0]       pixel_w;
  logic [PW*LANES-1:0] vec_new;

  generate
    if (PW > DW) begin : g_widen
      assign pixel_w = {{(PW-DW){(SIGN_EXTEND != 0) && ram_data[DW-1]}}, ram_data};
    end else begin : g_same
      assign pixel_w = ram_data;
    end
  endgenerate

  // A vector's final word may only be fetched when the output register will be free on its
  // arrival: the current vector is leaving (or absent) and no other final word is in flight.
  assign is_final = (lane_q == LW'(LANES-1)) || (remain_q == (AW+1)'(1));
  assign out_free = (!valid_q || data_ready) && !(pend_q && pend_final_q);
  assign issue    = (state_q == FETCH) && (!is_final || out_free);

  genvar gi;
  generate
    for (gi = 0; gi < LANES-1; gi++) begin : g_lane
      assign vec_new[gi*PW +: PW] = (LW'(gi) < pend_lane_q)  ? buf_q[gi] :
                                    (LW'(gi) == pend_lane_q) ? pixel_w   : '0;
    end
  endgenerate
  assign vec_new[(LANES-1)*PW +: PW] = (pend_lane_q == LW'(LANES-1)) ? pixel_w : '0;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    lane_d       = lane_q;
    buf_d        = buf_q;
    out_d        = out_q;
    valid_d      = valid_q;
    last_d       = last_q;
    pend_d       = issue;
    pend_lane_d  = lane_q;
    pend_final_d = is_final;
    pend_last_d  = (remain_q == (AW+1)'(1));

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = start_addr;
          remain_d = num_words;
          lane_d   = '0;
          state_d  = (num_words == '0) ? DONE_ST : FETCH;
        end
      end
      FETCH: begin
        if (issue) begin
          addr_d   = addr_q + AW'(1);
          remain_d = remain_q - (AW+1)'(1);
          lane_d   = is_final ? '0 : lane_q + LW'(1);
          if (remain_q == (AW+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (valid_q && last_q && data_ready) state_d = DONE_ST;
      end
      default: state_d = IDLE;
    endcase

    if (valid_q && data_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    // Data from last cycle's read lands either in the fill buffer or, with the buffer, in the output.
    if (pend_q) begin
      if (pend_final_q) begin
        out_d   = vec_new;
        valid_d = 1'b1;
        last_d  = pend_last_q;
      end else begin
        buf_d[pend_lane_q] = pixel_w;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      lane_q       <= '0;
      pend_q       <= 1'b0;
      pend_lane_q  <= '0;
      pend_final_q <= 1'b0;
      pend_last_q  <= 1'b0;
      for (int i = 0; i < LANES-1; i++) buf_q[i] <= '0;
      out_q        <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      lane_q       <= lane_d;
      pend_q       <= pend_d;
      pend_lane_q  <= pend_lane_d;
      pend_final_q <= pend_final_d;
      pend_last_q  <= pend_last_d;
      buf_q        <= buf_d;
      out_q        <= out_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
    end
  end

  assign ram_rd_en   = issue;
  assign ram_address = issue ? addr_q : '0;
  assign data_out    = out_q;
  assign data_valid  = valid_q;
  assign data_last   = last_q;
  assign busy        = (state_q == FETCH) || (state_q == DRAIN);
  assign done        = (state_q == DONE_ST);

endmodule

// File: tb/tb_ram_vector_streamer.sv
// Bench for ram_vector_streamer: table of spans checked through a vector scoreboard,
// plus hand-written backpressure, zero-span, reset and sign-extension sequences.
module tb_ram_vector_streamer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, data_ready;
  logic [5:0]  start_addr, ram_address;
  logic [6:0]  num_words;
  logic        ram_rd_en, data_valid, data_last, busy, done;
  logic [7:0]  ram_data;
  logic [63:0] data_out;

  logic        start_s, data_ready_s;
  logic [5:0]  start_addr_s, ram_address_s;
  logic [6:0]  num_words_s;
  logic        ram_rd_en_s, data_valid_s, data_last_s, busy_s, done_s;
  logic [7:0]  ram_data_s;
  logic [63:0] data_out_s;

  logic [7:0]  mem   [64];
  logic [7:0]  mem_s [64];

  ram_vector_streamer #(.RAM_ADDR_WIDTH(6), .RAM_DATA_WIDTH(8), .PE_DATA_WIDTH(16),
                        .LANES(4), .SIGN_EXTEND(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .num_words(num_words), .ram_address(ram_address), .ram_rd_en(ram_rd_en),
    .ram_data(ram_data), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .data_last(data_last), .busy(busy), .done(done));

  ram_vector_streamer #(.RAM_ADDR_WIDTH(6), .RAM_DATA_WIDTH(8), .PE_DATA_WIDTH(16),
                        .LANES(4), .SIGN_EXTEND(1)) dut_se (
    .clk(clk), .reset_n(reset_n), .start(start_s), .start_addr(start_addr_s),
    .num_words(num_words_s), .ram_address(ram_address_s), .ram_rd_en(ram_rd_en_s),
    .ram_data(ram_data_s), .data_out(data_out_s), .data_valid(data_valid_s),
    .data_ready(data_ready_s), .data_last(data_last_s), .busy(busy_s), .done(done_s));

  always @(posedge clk) if (ram_rd_en)   ram_data   <= mem[ram_address];
  always @(posedge clk) if (ram_rd_en_s) ram_data_s <= mem_s[ram_address_s];

  typedef struct {
    logic [5:0]  sa;
    logic [6:0]  nw;
    int          exp_lat;
    int          exp_nvec;
    logic [63:0] exp_first;
    logic [63:0] exp_last;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic [63:0] got[$];
  int          done_cnt = 0;
  int          rd_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Model: mem[i] = i, so lane l of vector v holds (sa + v*4 + l) mod 64, zero past the span.
  task automatic push_model(input logic [5:0] sa, input logic [6:0] nw);
    int   nv;
    exp_t e;
    nv = (int'(nw) + 3) / 4;
    for (int v = 0; v < nv; v++) begin
      e.data = '0;
      for (int l = 0; l < 4; l++) begin
        if (v*4 + l < int'(nw)) e.data[l*16 +: 16] = 16'((int'(sa) + v*4 + l) % 64);
      end
      e.last = (v == nv - 1);
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && data_valid && data_ready) begin
      exp_t e;
      got.push_back(data_out);
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_data", data_out, e.data);
        check("sb_last", 64'(data_last), 64'(e.last));
      end
    end
    if (done) done_cnt++;
  end

  always @(posedge clk) if (ram_rd_en) rd_cnt++;

  task automatic wait_done(input int base_done, input string tag);
    int k;
    k = 0;
    while (done_cnt == base_done && k < 400) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != base_done), 64'd1);
  endtask

  task automatic run(input vec_t t, input string tag);
    int k, base_vec, base_done;
    @(posedge clk); #1;
    base_vec = got.size();
    base_done = done_cnt;
    start = 1'b1; start_addr = t.sa; num_words = t.nw;
    push_model(t.sa, t.nw);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!data_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(t.exp_lat));
    wait_done(base_done, tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_nvec"}, 64'(got.size() - base_vec), 64'(t.exp_nvec));
    if (got.size() > base_vec) begin
      check({tag, "_first"}, got[base_vec], t.exp_first);
      check({tag, "_last"}, got[got.size()-1], t.exp_last);
    end
    check({tag, "_done_once"}, 64'(done_cnt - base_done), 64'd1);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    $display("xfer %s sa=%0d nw=%0d latency=%0d vectors=%0d", tag, t.sa, t.nw, k,
             got.size() - base_vec);
  endtask

  vec_t tbl [5];

  initial begin
    int   k, base_rd, base_vec, base_done;
    logic stable, seen;
    logic [63:0] snap;

    tbl[0] = '{6'd0,  7'd64, 5, 16, 64'h0003_0002_0001_0000, 64'h003F_003E_003D_003C};
    tbl[1] = '{6'd10, 7'd6,  5, 2,  64'h000D_000C_000B_000A, 64'h0000_0000_000F_000E};
    tbl[2] = '{6'd62, 7'd4,  5, 1,  64'h0001_0000_003F_003E, 64'h0001_0000_003F_003E};
    tbl[3] = '{6'd60, 7'd5,  5, 2,  64'h003F_003E_003D_003C, 64'h0000_0000_0000_0000};
    tbl[4] = '{6'd5,  7'd1,  2, 1,  64'h0000_0000_0000_0005, 64'h0000_0000_0000_0005};

    for (int i = 0; i < 64; i++) begin
      mem[i]   = 8'(i);
      mem_s[i] = 8'h00;
    end
    mem_s[0] = 8'h80;

    reset_n = 1'b1; start = 1'b0; start_addr = '0; num_words = '0; data_ready = 1'b1;
    start_s = 1'b0; start_addr_s = '0; num_words_s = '0; data_ready_s = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data_out", data_out, 64'd0);
    check("reset_ctrl", 64'({data_valid, data_last, ram_rd_en, ram_address, busy, done}), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Backpressure: stall once the first vector is valid; a spurious start must be ignored.
    @(posedge clk); #1;
    base_rd = rd_cnt; base_vec = got.size(); base_done = done_cnt;
    start = 1'b1; start_addr = 6'd0; num_words = 7'd16;
    push_model(6'd0, 7'd16);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!data_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_latency", 64'(k), 64'd5);
    data_ready = 1'b0;
    snap = data_out;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (data_out !== snap || !data_valid || data_last) stable = 1'b0;
      start = (c == 3);
      start_addr = 6'd20; num_words = 7'd3;
    end
    start = 1'b0;
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_reads", 64'(rd_cnt - base_rd), 64'd7);
    check("bp_rd_idle", 64'(ram_rd_en), 64'd0);
    data_ready = 1'b1;
    wait_done(base_done, "bp");
    repeat (3) @(posedge clk);
    #1;
    check("bp_nvec", 64'(got.size() - base_vec), 64'd4);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);
    $display("xfer backpressure reads=%0d vectors=%0d", rd_cnt - base_rd, got.size() - base_vec);

    // Zero-length span: done in the cycle after start, no data.
    @(posedge clk); #1;
    start = 1'b1; start_addr = 6'd7; num_words = 7'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done_t1", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    @(posedge clk); #1;
    check("zero_done_pulse", 64'(done), 64'd0);
    for (int c = 0; c < 6; c++) begin
      if (data_valid || ram_rd_en) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("zero_no_valid", 64'(seen), 64'd0);
    $display("xfer zero-span done_pulse_checked");

    // Asynchronous reset mid-stream, then a clean transfer.
    @(posedge clk); #1;
    start = 1'b1; start_addr = 6'd0; num_words = 7'd64;
    push_model(6'd0, 7'd64);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midreset_data_out", data_out, 64'd0);
    check("midreset_ctrl", 64'({data_valid, data_last, ram_rd_en, ram_address, busy, done}), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    $display("xfer mid-stream reset applied");
    run(tbl[1], "post_reset");

    // Sign extension on the second instance.
    @(posedge clk); #1;
    start_s = 1'b1; start_addr_s = 6'd0; num_words_s = 7'd1;
    @(posedge clk); #1;
    start_s = 1'b0;
    k = 0;
    while (!data_valid_s && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("sext_data", data_out_s, 64'h0000_0000_0000_FF80);
    check("sext_last", 64'(data_last_s), 64'd1);
    k = 0;
    while (!done_s && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("sext_done", 64'(done_s), 64'd1);
    $display("xfer sign-extend data=0x%0h", data_out_s);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
